ram_responder: RTL
==================

# ram_responder

Memory-side responder for the CPU data bus. Answers the RAM-side request strobes that the bus system drives (write strobe, start-read) with one-cycle `save_rdy` / `read_rdy` completion pulses. It owns the data RAM array and inserts a configurable number of wait states. It sits between the bus system's RAM port and the on-chip RAM, and is the responder for the bus system's initiator handshake.

## Interface
- `ADDR_W`, 15, word address width (matches bus address).
- `DATA_W`, 32, data word width.
- `DEPTH`, 8192, implemented words; addresses ≥ DEPTH are out of range.
- `WAIT_STATES`, 0, extra cycles inserted before each array access, legal 0..15.
- `clk`  in  1  single system clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `addr`  in  ADDR_W  request word address; sampled at accept.
- `wdata`  in  DATA_W  write data; sampled at accept.
- `w`  in  1  write request; sampled only in IDLE.
- `start_read`  in  1  read request; sampled only in IDLE.
- `rdata`  out  DATA_W  read data; holds last completed read.
- `read_rdy`  out  1  one-cycle pulse, `rdata` valid.
- `save_rdy`  out  1  one-cycle pulse, write committed.
- `busy`  out  1  high whenever state ≠ IDLE.

## Operation
- States: IDLE, WAIT, ACCESS, RDATA.
- **Accept.** In IDLE, `w=1` or `start_read=1` at an edge latches `addr`/`wdata` and the op type, loads the wait counter with WAIT_STATES, and moves to WAIT (or straight to ACCESS if WAIT_STATES=0).
- **WAIT.** Decrement the counter; go to ACCESS when it reaches 0.
- **ACCESS, write.** Assert array write-enable for one cycle, set `save_rdy<=1`, then go to IDLE (or to the pending read, see below).
- **ACCESS, read.** Present the latched address to the sync-read array, then go to RDATA.
- **RDATA.** `rdata<=array_q`, `read_rdy<=1`, then go to IDLE.
- **Simultaneous `w` and `start_read` in IDLE.** The write is served first and `read_pend` is set. After the write's ACCESS, the read starts at the same latched address (WAIT again if WAIT_STATES>0), so it returns the just-written data. `read_pend` clears at RDATA.
- **Requests while busy.** Ignored: no queueing and no error. The initiator must wait for the ready pulse.
- **Out of range (`addr ≥ DEPTH`).** The write is suppressed but `save_rdy` still pulses. A read returns 0 with `read_rdy`.
- **Arithmetic.** The range check is an unsigned compare on ADDR_W bits. The wait counter is 4 bits and saturates at 0.

## Timing
- **Reset values.** `rdata=0`, `read_rdy=0`, `save_rdy=0`, `busy=0`, state IDLE, `read_pend=0`. Array contents are not cleared.
- **Write latency.** Accept at edge k; the array is written at edge k+1+W; `save_rdy` is high for the single cycle after that edge.
- **Read latency.** Accept at edge k; `read_rdy` is high and `rdata` valid in the cycle after edge k+2+W.
- **Combined request.** `save_rdy` as for the write; `read_rdy` in the cycle after edge k+3+2W.
- **Back-to-back.** A new request can be accepted at the edge that ends the `save_rdy` or `read_rdy` cycle.
- **Ready pulses.** Registered, never high for two consecutive cycles from one request.
- **Reset mid-operation.** Asserting `rst` at any point returns to IDLE with all outputs 0 immediately. A write not yet past its ACCESS edge is not committed, and no ready pulse is produced for the aborted request.

## Structure
- Shared package (`bus_pkg`) holds:
  - the state enum `ram_resp_state_t`;
  - the default widths (`BUS_ADDR_W=15`, `BUS_DATA_W=32`);
  - `MAX_WAIT_STATES=15`.
- One sub-module, `ram_array`: single-port, synchronous-read, write-enable, DEPTH×DATA_W, no reset on the storage. It is kept separate so it can be swapped for a vendor RAM.
- The FSM, wait counter, pending flag, request latches and output registers live in `ram_responder`.

## Test plan
- **Basic write/read, W=0.** Write `addr=5`, `wdata=0xDEADBEEF` → `save_rdy` one cycle after edge k+1. Then read `addr=5` → `read_rdy` after edge k+2 with `rdata=0xDEADBEEF`.
- **Wait states, W=3.** Read of a preloaded `addr=0x10 (0x12345678)` → `read_rdy` exactly after edge k+5 and `busy` high for 5 cycles. Requests pulsed while busy are ignored, with no extra pulses.
- **Simultaneous request.** `w=1`, `start_read=1`, `addr=7`, `wdata=0xA5A5A5A5` → `save_rdy`, then `read_rdy` 2 cycles later (W=0) with `rdata=0xA5A5A5A5`.
- **Out of range, DEPTH=8192.** Write `0x7FFF` → `save_rdy` pulses and no array location changes. Read `0x7FFF` → `rdata=0` with `read_rdy`.
- **Reset mid-write.** Write `addr=3`, `0x11111111` over old value `0x22222222`, W=4. Assert `rst` on the second WAIT cycle → outputs 0, no `save_rdy`. After release, reading `addr=3` returns `0x22222222`.
- **Back-to-back writes.** Issue new `w` at each `save_rdy` cycle → one write accepted every 2 cycles (W=0), each acknowledged exactly once.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared CPU data-bus definitions: default widths, wait-state limit and the
// RAM responder state encoding.
package bus_pkg;

  localparam int BUS_ADDR_W      = 15;
  localparam int BUS_DATA_W      = 32;
  localparam int MAX_WAIT_STATES = 15;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS,
    S_RDATA
  } ram_resp_state_t;

endpackage

// File: rtl/ram_responder_if.sv
// RAM-side request/completion bundle between the bus system (master) and the
// RAM responder (slave).
interface ram_responder_if
  import bus_pkg::*;
#(
  parameter int ADDR_W = BUS_ADDR_W,
  parameter int DATA_W = BUS_DATA_W
);

  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              w;
  logic              start_read;
  logic [DATA_W-1:0] rdata;
  logic              read_rdy;
  logic              save_rdy;
  logic              busy;

  modport master (
    output addr, wdata, w, start_read,
    input  rdata, read_rdy, save_rdy, busy
  );

  modport slave (
    input  addr, wdata, w, start_read,
    output rdata, read_rdy, save_rdy, busy
  );

endinterface

// File: rtl/ram_responder_array.sv
// Single-port synchronous-read data RAM; storage is never reset so a vendor
// macro can replace this module one-for-one.
module ram_array #(
  parameter int DEPTH  = 8192,
  parameter int DATA_W = 32
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] addr_i,
  input  logic [DATA_W-1:0]        wdata_i,
  output logic [DATA_W-1:0]        rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ram_responder.sv
// Memory-side responder for the CPU data bus: accepts write/read strobes in
// IDLE, inserts WAIT_STATES wait cycles and answers with one-cycle ready pulses.
module ram_responder
  import bus_pkg::*;
#(
  parameter int ADDR_W      = BUS_ADDR_W,
  parameter int DATA_W      = BUS_DATA_W,
  parameter int DEPTH       = 8192,
  parameter int WAIT_STATES = 0
) (
  input logic            clk_i,
  input logic            rst_ni,
  ram_responder_if.slave bus
);

  localparam int              AW      = $clog2(DEPTH);
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);
  localparam logic [3:0]      WS      = 4'(WAIT_STATES);

  ram_resp_state_t   state_q;
  logic [3:0]        cnt_q;
  logic [3:0]        cnt_d;
  logic              rd_pend_q;
  logic              op_wr_q;
  logic              oor_q;
  logic [AW-1:0]     addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              read_rdy_q;
  logic              save_rdy_q;
  logic [DATA_W-1:0] array_q;
  logic              array_we;

  assign cnt_d    = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
  assign array_we = (state_q == S_ACCESS) && op_wr_q && !oor_q;

  ram_array #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_array (
    .clk_i   (clk_i),
    .we_i    (array_we),
    .addr_i  (addr_q),
    .wdata_i (wdata_q),
    .rdata_o (array_q)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      rd_pend_q  <= 1'b0;
      op_wr_q    <= 1'b0;
      oor_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      read_rdy_q <= 1'b0;
      save_rdy_q <= 1'b0;
    end else begin
      read_rdy_q <= 1'b0;
      save_rdy_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (bus.w || bus.start_read) begin
            addr_q    <= bus.addr[AW-1:0];
            wdata_q   <= bus.wdata;
            op_wr_q   <= bus.w;
            rd_pend_q <= bus.w && bus.start_read;
            oor_q     <= ({1'b0, bus.addr} >= DEPTH_X);
            cnt_q     <= WS;
            state_q   <= (WS == 4'd0) ? S_ACCESS : S_WAIT;
          end
        end
        S_WAIT: begin
          cnt_q <= cnt_d;
          if (cnt_d == 4'd0) begin
            state_q <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (op_wr_q) begin
            save_rdy_q <= 1'b1;
            // A combined request re-enters the wait/access path as a read of the same address.
            if (rd_pend_q) begin
              op_wr_q <= 1'b0;
              cnt_q   <= WS;
              state_q <= (WS == 4'd0) ? S_ACCESS : S_WAIT;
            end else begin
              state_q <= S_IDLE;
            end
          end else begin
            state_q <= S_RDATA;
          end
        end
        S_RDATA: begin
          rdata_q    <= oor_q ? '0 : array_q;
          read_rdy_q <= 1'b1;
          rd_pend_q  <= 1'b0;
          state_q    <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.rdata    = rdata_q;
  assign bus.read_rdy = read_rdy_q;
  assign bus.save_rdy = save_rdy_q;
  assign bus.busy     = (state_q != S_IDLE);

endmodule
